control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter MEM_HS, default 1, 1 = memory-class instructions wait on mem_ready, 0 = single-cycle execute (mem_ready ignored).
REQ-002 Parameter WAIT_MAX, default 15, range 1..255, max EXEC+MEMWAIT cycles without mem_ready before fault.
REQ-003 Parameter ICNT_W, default 16, width of retired-instruction counter.
REQ-004 Ports: clock input 1, single clock, all state on rising edge.
REQ-005 Ports: reset input 1, asynchronous, active-high.
REQ-006 Ports: run input 1, 1 = sequencing enabled, sampled in FETCH only.
REQ-007 Ports: instr_op input 4, opcode from program ROM, valid during FETCH.
REQ-008 Ports: carry, zero inputs 1 each, ALU flags, sampled combinationally in EXEC.
REQ-009 Ports: mem_ready input 1, RAM access complete.
REQ-010 Ports: signals output 13, control word: [12] pc_inc, [11] pc_load, [10] acc_load, [9] flags_load, [8:6] alu_sel, [5] ram_cs, [4] ram_we, [3] rom_oe, [2] in_en, [1] imm_en, [0] out_en.
REQ-011 Ports: phase output 2, state code: FETCH=0, EXEC=1, MEMWAIT=2, HALT=3.
REQ-012 Ports: fault output 1, registered, wait timeout occurred.
REQ-013 Ports: retired output ICNT_W, count of completed instructions.

Function
REQ-014 FSM states FETCH, EXEC, MEMWAIT, HALT; phase reflects current state.
REQ-015 FETCH, run=1: signals=0x1008; opcode register loads instr_op; next state EXEC.
REQ-016 FETCH, run=0: signals=0x0000; opcode register holds; stay FETCH.
REQ-017 EXEC decode (hex): 0 JC: carry?0x0808:0x1008; 1 JNC: carry?0x1008:0x0808; 2 CMPI 0x0242; 3 CMPM 0x1260; 4 LIT 0x0682; 5 IN 0x0684; 6 LD 0x16A0; 7 ST 0x1038; 8 JZ: zero?0x0808:0x1008; 9 JNZ: zero?0x1008:0x0808; A ADDI 0x06C2; B ADDM 0x16E0; C JMP 0x0808; D OUT 0x0009; E NANDI 0x0702; F NANDM 0x1720.
REQ-018 Memory-class opcodes: 3, 6, 7, B, F; all others are single-cycle: EXEC -> FETCH unconditionally.
REQ-019 MEM_HS=1, memory-class, EXEC or MEMWAIT: signals = decoded word with bits [12:9] forced 0 while mem_ready=0; full decoded word in the cycle mem_ready=1.
REQ-020 MEM_HS=1: EXEC with mem_ready=1 -> FETCH; EXEC with mem_ready=0 -> MEMWAIT; MEMWAIT holds until mem_ready=1 -> FETCH.
REQ-021 MEM_HS=0: memory-class treated as single-cycle, full decoded word, EXEC -> FETCH.
REQ-022 Wait counter: cleared on entry to EXEC, increments each EXEC/MEMWAIT cycle with mem_ready=0 for a memory-class instruction.
REQ-023 Wait counter reaching WAIT_MAX with mem_ready still 0 -> HALT next edge, fault set to 1; mem_ready=1 in that same cycle wins (completes, no fault).
REQ-024 HALT: signals=0x0000, fault=1, phase=3; exits only via reset.
REQ-025 retired increments by 1 on the edge leaving EXEC/MEMWAIT to FETCH; wraps from all-ones to 0; never increments on fault.
REQ-026 Jump flags are sampled in the EXEC cycle, not latched at FETCH.
REQ-027 signals and phase are combinational from state, opcode register, flags, and mem_ready; no extra output latency.

Reset
REQ-028 reset asserted: state FETCH, opcode register 0, wait counter 0, fault 0, retired 0, immediately and independent of clock.
REQ-029 While reset=1, signals SHALL be forced to 0x0000; first cycle after release is FETCH.
REQ-030 Reset mid-MEMWAIT or in HALT aborts without incrementing retired and clears fault.

Verification
REQ-031 Reset release, run=1, instr_op=0x4 -> FETCH signals 0x1008, next cycle EXEC signals 0x0682, retired=1 after.
REQ-032 JC with carry=1 -> 0x0808; JC with carry=0 -> 0x1008; JNZ with zero=1 -> 0x1008.
REQ-033 MEM_HS=1, LD, mem_ready low 3 cycles then high -> signals 0x00A0 for 3 cycles (phase 1,2,2), then 0x16A0, then FETCH; retired +1.
REQ-034 WAIT_MAX=4, ST, mem_ready held 0 -> HALT after 4 wait cycles, fault=1, signals 0x0000, retired unchanged; assert reset -> fault 0, phase 0.
REQ-035 run=0 in FETCH for 5 cycles -> signals 0x0000, phase 0, retired constant; ICNT_W=4, 16 instructions -> retired wraps to 0.

Source files
------------

// File: rtl/control_sequencer.sv
// Control sequencer: fetch/execute FSM producing the datapath control word,
// with optional memory handshake, wait-timeout fault and retired counter.
module control_sequencer #(
  parameter int unsigned MEM_HS   = 1,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned ICNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        instr_op,
  input  logic              carry,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [12:0]       signals,
  output logic [1:0]        phase,
  output logic              fault,
  output logic [ICNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StExec    = 2'd1,
    StMemWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              fault_q, fault_d;
  logic [ICNT_W-1:0] retired_q, retired_d;

  logic [12:0] decoded;
  logic        is_mem;
  logic        wait_hit;

  // Decode the latched opcode; jump flags are taken live in the execute cycle.
  always_comb begin
    decoded = 13'h0000;
    is_mem  = 1'b0;
    unique case (opcode_q)
      4'h0: decoded = carry ? 13'h0808 : 13'h1008;
      4'h1: decoded = carry ? 13'h1008 : 13'h0808;
      4'h2: decoded = 13'h0242;
      4'h3: begin decoded = 13'h1260; is_mem = 1'b1; end
      4'h4: decoded = 13'h0682;
      4'h5: decoded = 13'h0684;
      4'h6: begin decoded = 13'h16A0; is_mem = 1'b1; end
      4'h7: begin decoded = 13'h1038; is_mem = 1'b1; end
      4'h8: decoded = zero ? 13'h0808 : 13'h1008;
      4'h9: decoded = zero ? 13'h1008 : 13'h0808;
      4'hA: decoded = 13'h06C2;
      4'hB: begin decoded = 13'h16E0; is_mem = 1'b1; end
      4'hC: decoded = 13'h0808;
      4'hD: decoded = 13'h0009;
      4'hE: decoded = 13'h0702;
      4'hF: begin decoded = 13'h1720; is_mem = 1'b1; end
      default: decoded = 13'h0000;
    endcase
  end

  // This wait cycle is the last one allowed before the timeout trips.
  assign wait_hit = ({24'd0, wait_cnt_q} + 32'd1) >= WAIT_MAX;

  // Next-state and control word generation.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    retired_d  = retired_q;
    signals    = 13'h0000;
    unique case (state_q)
      StFetch: begin
        if (run) begin
          signals    = 13'h1008;
          opcode_d   = instr_op;
          wait_cnt_d = 8'd0;
          state_d    = StExec;
        end
      end
      StExec, StMemWait: begin
        if (is_mem && (MEM_HS != 0)) begin
          if (mem_ready) begin
            signals   = decoded;
            retired_d = retired_q + 1'b1;
            state_d   = StFetch;
          end else begin
            // Hold off register writes until the RAM access completes.
            signals = decoded & 13'h01FF;
            if (wait_hit) begin
              fault_d = 1'b1;
              state_d = StHalt;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
              state_d    = StMemWait;
            end
          end
        end else begin
          signals   = decoded;
          retired_d = retired_q + 1'b1;
          state_d   = StFetch;
        end
      end
      StHalt: fault_d = 1'b1;
      default: state_d = StFetch;
    endcase
    if (reset) signals = 13'h0000;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      opcode_q   <= 4'h0;
      wait_cnt_q <= 8'd0;
      fault_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      retired_q  <= retired_d;
    end
  end

  assign phase   = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: handshake/timeout instance and a
// single-cycle (no handshake) instance sharing the same stimulus.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        carry = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  instr_op = 4'h0;

  logic [12:0] sig_a, sig_b;
  logic [1:0]  ph_a, ph_b;
  logic        fault_a, fault_b;
  logic [3:0]  ret_a;
  logic [15:0] ret_b;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  control_sequencer #(.MEM_HS(1), .WAIT_MAX(4), .ICNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .run(run), .instr_op(instr_op), .carry(carry),
    .zero(zero), .mem_ready(mem_ready), .signals(sig_a), .phase(ph_a),
    .fault(fault_a), .retired(ret_a)
  );

  control_sequencer #(.MEM_HS(0)) dut_b (
    .clock(clock), .reset(reset), .run(run), .instr_op(instr_op), .carry(carry),
    .zero(zero), .mem_ready(mem_ready), .signals(sig_b), .phase(ph_b),
    .fault(fault_b), .retired(ret_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One single-cycle instruction on dut_a: flags at fetch, then flags at execute.
  task automatic single(input logic [3:0] op, input logic c_f, input logic z_f,
                        input logic c_e, input logic z_e, input logic [12:0] exp);
    run = 1'b1; instr_op = op; carry = c_f; zero = z_f;
    #1;
    check("fetch_sig", sig_a, 13'h1008);
    check("fetch_phase", ph_a, 2'd0);
    @(negedge clock);
    run = 1'b0; instr_op = 4'h7; carry = c_e; zero = z_e;
    #1;
    check($sformatf("exec_sig_op%0h", op), sig_a, exp);
    check("exec_phase", ph_a, 2'd1);
    @(negedge clock);
  endtask

  initial begin
    // Reset dominates outputs even with run asserted.
    run = 1'b1; instr_op = 4'h4;
    #3;
    check("rst_sig", sig_a, 13'h0000);
    check("rst_phase", ph_a, 2'd0);
    check("rst_fault", fault_a, 1'b0);
    check("rst_retired", ret_a, 4'd0);
    @(negedge clock);
    reset = 1'b0;

    single(4'h4, 0, 0, 0, 0, 13'h0682);
    check("lit_retired", ret_a, 4'd1);
    check("lit_phase", ph_a, 2'd0);

    // Flags are taken in execute, not at fetch.
    single(4'h0, 0, 0, 1, 0, 13'h0808);
    single(4'h0, 1, 0, 0, 0, 13'h1008);
    single(4'h9, 0, 0, 0, 1, 13'h1008);
    single(4'h2, 0, 0, 0, 0, 13'h0242);
    single(4'hA, 0, 0, 0, 0, 13'h06C2);
    single(4'hD, 0, 0, 0, 0, 13'h0009);
    single(4'hE, 0, 0, 0, 0, 13'h0702);
    single(4'hC, 0, 0, 0, 0, 13'h0808);
    single(4'h5, 0, 0, 0, 0, 13'h0684);
    single(4'h8, 0, 0, 0, 1, 13'h0808);
    single(4'h1, 0, 0, 0, 0, 13'h0808);
    check("retired_12", ret_a, 4'd12);

    // Memory op completing immediately.
    mem_ready = 1'b1;
    single(4'hB, 0, 0, 0, 0, 13'h16E0);
    check("addm_phase", ph_a, 2'd0);
    check("retired_13", ret_a, 4'd13);

    // LD with three stalled cycles.
    mem_ready = 1'b0; run = 1'b1; instr_op = 4'h6;
    @(negedge clock);
    run = 1'b0;
    #1;
    check("ld_w0_sig", sig_a, 13'h00A0);
    check("ld_w0_phase", ph_a, 2'd1);
    repeat (2) begin
      @(negedge clock);
      #1;
      check("ld_wn_sig", sig_a, 13'h00A0);
      check("ld_wn_phase", ph_a, 2'd2);
    end
    @(negedge clock);
    mem_ready = 1'b1;
    #1;
    check("ld_done_sig", sig_a, 13'h16A0);
    check("ld_done_phase", ph_a, 2'd2);
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    check("ld_fetch_phase", ph_a, 2'd0);
    check("retired_14", ret_a, 4'd14);

    // Idle with run low.
    repeat (5) begin
      #1;
      check("idle_sig", sig_a, 13'h0000);
      check("idle_phase", ph_a, 2'd0);
      @(negedge clock);
    end
    check("idle_retired", ret_a, 4'd14);

    // ST never acknowledged: timeout after four wait cycles.
    run = 1'b1; instr_op = 4'h7;
    @(negedge clock);
    run = 1'b0;
    #1;
    check("st_w0_sig", sig_a, 13'h0038);
    repeat (3) begin
      @(negedge clock);
      #1;
      check("st_wn_phase", ph_a, 2'd2);
    end
    @(negedge clock);
    #1;
    check("halt_phase", ph_a, 2'd3);
    check("halt_fault", fault_a, 1'b1);
    check("halt_sig", sig_a, 13'h0000);
    check("halt_retired", ret_a, 4'd14);
    run = 1'b1; mem_ready = 1'b1; instr_op = 4'h4;
    @(negedge clock);
    #1;
    check("halt_sticky", ph_a, 2'd3);
    reset = 1'b1;
    #1;
    check("rst2_fault", fault_a, 1'b0);
    check("rst2_phase", ph_a, 2'd0);
    check("rst2_retired", ret_a, 4'd0);
    @(negedge clock);
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0;

    // NANDM: ready arrives in the last allowed wait cycle and wins.
    run = 1'b1; instr_op = 4'hF;
    @(negedge clock);
    run = 1'b0;
    repeat (3) @(negedge clock);
    mem_ready = 1'b1;
    #1;
    check("nandm_last_sig", sig_a, 13'h1720);
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    check("nandm_phase", ph_a, 2'd0);
    check("nandm_fault", fault_a, 1'b0);
    check("nandm_retired", ret_a, 4'd1);

    // Retired counter wrap at 4 bits.
    repeat (14) single(4'h4, 0, 0, 0, 0, 13'h0682);
    check("retired_15", ret_a, 4'd15);
    single(4'h4, 0, 0, 0, 0, 13'h0682);
    check("retired_wrap", ret_a, 4'd0);

    // Without handshake, memory ops are single-cycle with the full word.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b0; run = 1'b1; instr_op = 4'h6;
    @(negedge clock);
    run = 1'b0;
    #1;
    check("b_ld_sig", sig_b, 13'h16A0);
    check("b_ld_phase", ph_b, 2'd1);
    @(negedge clock);
    run = 1'b1; instr_op = 4'h3;
    #1;
    check("b_ld_fetch", ph_b, 2'd0);
    check("b_retired_1", ret_b, 16'd1);
    @(negedge clock);
    run = 1'b0;
    #1;
    check("b_cmpm_sig", sig_b, 13'h1260);
    @(negedge clock);
    #1;
    check("b_retired_2", ret_b, 16'd2);
    check("b_fault", fault_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
